// File: rtl/truth_table_monitor.sv
// Response-capture monitor for a 3-input combinational unit.
// It builds the observed truth table, tracks which input combinations have been covered
// and catches inconsistent responses. When collection ends it reports the result against EXPECTED.
module truth_table_monitor #(
  parameter logic [7:0]  EXPECTED    = 8'hE8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       smp_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic       conflict,
  output logic [7:0] covered,
  output logic [7:0] observed,
  output logic [3:0] err_count,
  output logic [2:0] first_err_idx
);

  localparam int unsigned      ERR_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REPORT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d, pass_d, timeout_d, conflict_d;
  logic [7:0]       covered_d, observed_d;
  logic [ERR_W-1:0] err_d;
  logic [2:0]       first_d;
  logic [2:0]       idx;

  assign idx = {a, b, c};

  // State, counter and registered outputs; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      conflict      <= 1'b0;
      covered       <= '0;
      observed      <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      timeout       <= timeout_d;
      conflict      <= conflict_d;
      covered       <= covered_d;
      observed      <= observed_d;
      err_count     <= err_d;
      first_err_idx <= first_d;
    end
  end

  // Next-state and table update; start overrides everything and drops a coincident sample
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy;
    done_d     = done;
    pass_d     = pass;
    timeout_d  = timeout;
    conflict_d = conflict;
    covered_d  = covered;
    observed_d = observed;
    err_d      = err_count;
    first_d    = first_err_idx;

    if (start) begin
      state_d    = S_COLLECT;
      cnt_d      = '0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      timeout_d  = 1'b0;
      conflict_d = 1'b0;
      covered_d  = '0;
      observed_d = '0;
      err_d      = '0;
      first_d    = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (smp_valid) begin
            if (!covered[idx]) begin
              covered_d[idx]  = 1'b1;
              observed_d[idx] = y;
              if (y != EXPECTED[idx]) begin
                if (err_count == '0) first_d = idx;
                if (err_count != ERR_MAX) err_d = ERR_W'(err_count + ERR_W'(1));
              end
            end else if (y != observed[idx]) begin
              conflict_d = 1'b1;
            end
          end
          // Completing coverage takes priority over a coincident timeout
          if (covered_d == 8'hFF) begin
            state_d   = S_REPORT;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b0;
            pass_d    = ~conflict_d && (err_d == '0);
          end else if (cnt_q == CNT_LAST) begin
            state_d   = S_REPORT;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end else begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_monitor.sv
// Randomised and directed bench for truth_table_monitor.
// Two instances share the stimulus: one uses the default timeout and one a 16-cycle timeout.
// A table-level model predicts every output on every cycle.
module tb_truth_table_monitor;

  localparam int unsigned TO0 = 1024;
  localparam int unsigned TO1 = 16;

  logic clk = 1'b0;
  logic rst_n, start, smp_valid, a, b, c, y;

  logic [1:0] busy_o, done_o, pass_o, to_o, conf_o;
  logic [7:0] cov_o   [2];
  logic [7:0] obs_o   [2];
  logic [3:0] err_o   [2];
  logic [2:0] first_o [2];

  int checks   = 0;
  int failures = 0;

  // Model state per instance: 0 idle, 1 collecting, 2 reporting
  int       m_mode  [2];
  logic [7:0] m_cov [2];
  logic [7:0] m_obs [2];
  bit       m_conf  [2];
  bit       m_to    [2];
  int       m_nerr  [2];
  int       m_first [2];
  int       m_n     [2];

  always #5 clk = ~clk;

  truth_table_monitor #(.EXPECTED(8'hE8), .TIMEOUT_CYC(TO0), .CNT_W(11)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .c(c), .y(y),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .timeout(to_o[0]),
    .conflict(conf_o[0]), .covered(cov_o[0]), .observed(obs_o[0]),
    .err_count(err_o[0]), .first_err_idx(first_o[0])
  );

  truth_table_monitor #(.EXPECTED(8'hE8), .TIMEOUT_CYC(TO1), .CNT_W(11)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .c(c), .y(y),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .timeout(to_o[1]),
    .conflict(conf_o[1]), .covered(cov_o[1]), .observed(obs_o[1]),
    .err_count(err_o[1]), .first_err_idx(first_o[1])
  );

  function automatic bit maj(input int i);
    int ones;
    ones = (i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1);
    return ones >= 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    m_cov[k] = '0; m_obs[k] = '0; m_conf[k] = 0; m_to[k] = 0;
    m_nerr[k] = 0; m_first[k] = 0; m_n[k] = 0;
  endtask

  task automatic model_step(input int k, input int tmo);
    int i;
    i = {29'd0, a, b, c};
    if (!rst_n) begin
      model_clear(k);
      m_mode[k] = 0;
    end else if (start) begin
      model_clear(k);
      m_mode[k] = 1;
    end else if (m_mode[k] == 1) begin
      m_n[k]++;
      if (smp_valid) begin
        if (!m_cov[k][i]) begin
          m_cov[k][i] = 1'b1;
          m_obs[k][i] = y;
          if (y != maj(i)) begin
            if (m_nerr[k] == 0) m_first[k] = i;
            m_nerr[k]++;
          end
        end else if (y != m_obs[k][i]) begin
          m_conf[k] = 1;
        end
      end
      if (m_cov[k] == 8'hFF) begin
        m_mode[k] = 2; m_to[k] = 0;
      end else if (m_n[k] == tmo) begin
        m_mode[k] = 2; m_to[k] = 1;
      end
    end
  endtask

  // Reference model advances on every active edge
  always @(posedge clk) begin
    model_step(0, int'(TO0));
    model_step(1, int'(TO1));
  end

  task automatic cmp_inst(input int k);
    bit dn;
    int e_err, e_first, e_pass, e_to;
    dn      = (m_mode[k] == 2);
    e_err   = (m_nerr[k] > 15) ? 15 : m_nerr[k];
    e_first = (m_nerr[k] > 0) ? m_first[k] : 0;
    e_pass  = (dn && m_cov[k] == 8'hFF && !m_conf[k] && m_nerr[k] == 0) ? 1 : 0;
    e_to    = (dn && m_to[k]) ? 1 : 0;
    chk($sformatf("u%0d.busy", k),     int'(busy_o[k]), (m_mode[k] == 1) ? 1 : 0);
    chk($sformatf("u%0d.done", k),     int'(done_o[k]), dn ? 1 : 0);
    chk($sformatf("u%0d.pass", k),     int'(pass_o[k]), e_pass);
    chk($sformatf("u%0d.timeout", k),  int'(to_o[k]), e_to);
    chk($sformatf("u%0d.conflict", k), int'(conf_o[k]), int'(m_conf[k]));
    chk($sformatf("u%0d.covered", k),  int'(cov_o[k]), int'(m_cov[k]));
    chk($sformatf("u%0d.observed", k), int'(obs_o[k]), int'(m_obs[k]));
    chk($sformatf("u%0d.err_count", k), int'(err_o[k]), e_err);
    chk($sformatf("u%0d.first_err", k), int'(first_o[k]), e_first);
  endtask

  // Compare every output of both instances against the model mid-cycle
  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      cmp_inst(0);
      cmp_inst(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input int i, input bit yv);
    smp_valid = 1'b1;
    {a, b, c} = 3'(i);
    y = yv;
    tick();
    smp_valid = 1'b0;
  endtask

  // Sweep indices 0..7 spaced ten cycles apart, then check the outcome right after the last sample
  task automatic sweep(input int bad_idx, input int rep_idx);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (9) tick();
      sample(i, (i == bad_idx) ? 1'b0 : maj(i));
      if (i == rep_idx) begin
        repeat (9) tick();
        sample(i, ~maj(i));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; smp_valid = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; y = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0;
      model_clear(k);
    end
    tick(); tick();
    chk("lit.reset_busy", int'(busy_o[0]), 0);
    chk("lit.reset_cov", int'(cov_o[0]), 0);
    rst_n = 1'b1;
    tick();

    sweep(-1, -1);
    chk("lit.s1_done", int'(done_o[0]), 1);
    chk("lit.s1_cov", int'(cov_o[0]), 8'hFF);
    chk("lit.s1_obs", int'(obs_o[0]), 8'hE8);
    chk("lit.s1_pass", int'(pass_o[0]), 1);
    chk("lit.s1_err", int'(err_o[0]), 0);
    chk("lit.s1_to", int'(to_o[0]), 0);
    repeat (3) tick();

    sweep(3, -1);
    chk("lit.s2_err", int'(err_o[0]), 1);
    chk("lit.s2_first", int'(first_o[0]), 3);
    chk("lit.s2_obs", int'(obs_o[0]), 8'hE0);
    chk("lit.s2_pass", int'(pass_o[0]), 0);
    chk("lit.s2_conf", int'(conf_o[0]), 0);
    repeat (3) tick();

    sweep(-1, 5);
    chk("lit.s3_conf", int'(conf_o[0]), 1);
    chk("lit.s3_err", int'(err_o[0]), 0);
    chk("lit.s3_pass", int'(pass_o[0]), 0);
    chk("lit.s3_obs5", int'(obs_o[0][5]), 1);
    repeat (3) tick();

    // Timeout on the 16-cycle instance: indices 0..6 only
    pulse_start();
    for (int i = 0; i < 7; i++) sample(i, maj(i));
    repeat (8) tick();
    chk("lit.to_early_done", int'(done_o[1]), 0);
    tick();
    chk("lit.to_done", int'(done_o[1]), 1);
    chk("lit.to_flag", int'(to_o[1]), 1);
    chk("lit.to_cov", int'(cov_o[1]), 8'h7F);
    chk("lit.to_pass", int'(pass_o[1]), 0);

    // start together with a sample: the sample is dropped
    pulse_start();
    sample(0, 1'b0);
    start = 1'b1;
    sample(2, 1'b0);
    start = 1'b0;
    chk("lit.restart_cov", int'(cov_o[0]), 0);
    chk("lit.restart_busy", int'(busy_o[0]), 1);

    // Fill the table, then show samples are ignored in REPORT
    for (int i = 0; i < 8; i++) sample(i, maj(i));
    chk("lit.fill_done", int'(done_o[0]), 1);
    for (int i = 0; i < 8; i++) sample(i, ~maj(i));
    chk("lit.rep_obs", int'(obs_o[0]), 8'hE8);
    chk("lit.rep_err", int'(err_o[0]), 0);

    // Reset while reporting, then samples in IDLE
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("lit.rst_done", int'(done_o[0]), 0);
    chk("lit.rst_obs", int'(obs_o[0]), 0);
    for (int i = 0; i < 8; i++) sample(i, 1'b1);
    chk("lit.idle_cov", int'(cov_o[0]), 0);
    chk("lit.idle_busy", int'(busy_o[0]), 0);

    // Randomised traffic with occasional restarts, resets and wrong responses
    for (int n = 0; n < 4000; n++) begin
      int i;
      rst_n     = ($urandom_range(0, 249) != 0);
      start     = ($urandom_range(0, 39) == 0);
      smp_valid = $urandom_range(0, 1) == 1;
      i         = int'($urandom_range(0, 7));
      {a, b, c} = 3'(i);
      y         = maj(i) ^ ($urandom_range(0, 9) == 0);
      tick();
    end
    rst_n = 1'b1; start = 1'b0; smp_valid = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
